// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: decodes the latched IR, sequences
// FETCH/DECODE/EXEC/MEM/WB and drives every datapath control line.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        dm_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic        GRFWrEn,
  output logic        DMWrEn,
  output logic        dm_req,
  output logic        EXTOp,
  output logic [2:0]  NPCOp,
  output logic [4:0]  ALUOp,
  output logic [2:0]  ALUBSel,
  output logic        sllOp,
  output logic [2:0]  WDSel,
  output logic [2:0]  WRA3Sel,
  output logic [2:0]  DMOp,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  // state  | meaning
  // FETCH  | load IR from instruction memory
  // DECODE | IR stable, selects settle
  // EXEC   | ALU operates; control-flow instructions retire here
  // MEM    | data memory request held until dm_ack
  // WB     | register write-back and PC advance
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_SLL, C_JR, C_ORI, C_LUI,
    C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } cls_t;

  state_t      state_q, state_d;
  cls_t        cls;
  logic [31:0] cnt_q, cnt_d;
  logic        retires_in_exec;

  always_comb begin
    cls = C_ILL;
    case (opcode)
      6'h00: begin
        case (func)
          6'h20:   cls = C_ADD;
          6'h22:   cls = C_SUB;
          6'h00:   cls = C_SLL;
          6'h08:   cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      6'h0D:   cls = C_ORI;
      6'h0F:   cls = C_LUI;
      6'h23:   cls = C_LW;
      6'h2B:   cls = C_SW;
      6'h04:   cls = C_BEQ;
      6'h02:   cls = C_J;
      6'h03:   cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end

  assign retires_in_exec = (cls == C_BEQ) || (cls == C_J) || (cls == C_JR) ||
                           (cls == C_JAL) || (cls == C_ILL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (retires_in_exec)                     state_d = S_FETCH;
        else if ((cls == C_LW) || (cls == C_SW)) state_d = S_MEM;
        else                                     state_d = S_WB;
      end
      S_MEM: begin
        if (dm_ack) state_d = (cls == C_LW) ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    GRFWrEn = 1'b0;
    DMWrEn  = 1'b0;
    dm_req  = 1'b0;
    illegal = 1'b0;
    EXTOp   = 1'b0;
    NPCOp   = 3'd0;
    ALUOp   = 5'd0;
    ALUBSel = 3'd0;
    sllOp   = 1'b0;
    WDSel   = 3'd0;
    WRA3Sel = 3'd0;
    // IR contents are only meaningful once FETCH has loaded it
    if (state_q != S_FETCH) begin
      case (cls)
        C_ADD: begin ALUOp = 5'd0; WDSel = 3'd1; end
        C_SUB: begin ALUOp = 5'd1; WDSel = 3'd1; end
        C_SLL: begin ALUOp = 5'd4; sllOp = 1'b1; WDSel = 3'd1; end
        C_ORI: begin ALUOp = 5'd2; ALUBSel = 3'd1; WDSel = 3'd1; WRA3Sel = 3'd1; end
        C_LUI: begin ALUOp = 5'd3; ALUBSel = 3'd1; WDSel = 3'd1; WRA3Sel = 3'd1; end
        C_LW:  begin ALUBSel = 3'd1; EXTOp = 1'b1; WRA3Sel = 3'd1; end
        C_SW:  begin ALUBSel = 3'd1; EXTOp = 1'b1; end
        C_BEQ: begin ALUOp = 5'd1; NPCOp = 3'd1; end
        C_J:   NPCOp = 3'd2;
        C_JAL: begin NPCOp = 3'd2; WDSel = 3'd2; WRA3Sel = 3'd2; end
        C_JR:  NPCOp = 3'd3;
        default: ;
      endcase
    end
    case (state_q)
      S_FETCH: ir_we = 1'b1;
      S_EXEC: begin
        pc_we   = retires_in_exec;
        GRFWrEn = (cls == C_JAL);
        illegal = (cls == C_ILL);
      end
      S_MEM: begin
        dm_req = 1'b1;
        DMWrEn = (cls == C_SW);
        pc_we  = dm_ack && (cls == C_SW);
      end
      S_WB: begin
        GRFWrEn = 1'b1;
        pc_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cnt_d     = pc_we ? cnt_q + 32'd1 : cnt_q;
  assign instr_cnt = cnt_q;
  assign state     = state_q;
  assign DMOp      = 3'd0;

endmodule
